circ_rw_sequencer_ne: RTL and testbench



---
 rtl/circ_rw_sequencer_ne.sv | 161 ++++++++++++++++
 tb/tb_circ_rw_sequencer_ne.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/circ_rw_sequencer_ne.sv
// circ_rw_sequencer_ne
// Address/control sequencer in front of the column RAM for one circulant
// block. The Z column entries are read in cyclically shifted order, each word
// goes to the PE, and the PE result is written back to the address it came
// from, PROC_LAT+1 cycles after the read.
//
// Optional build macro: NE_WB_SAT_EN
//   defined     -> DIN is pe_result saturated to the signed W-bit range
//   not defined -> DIN is pe_result truncated to its low W bits
module circ_rw_sequencer_ne #(
  parameter int Z            = 511,
  parameter int W            = 6,
  parameter int COLADDR_BITS = 9,
  parameter int PROC_LAT     = 2
) (
  input  logic                    memclk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [COLADDR_BITS-1:0] shift,
  output logic                    busy,
  output logic                    done,
  output logic [COLADDR_BITS-1:0] RA,
  output logic                    rd_in,
  input  logic [W-1:0]            ram_dout,
  output logic [W-1:0]            pe_data,
  output logic                    pe_valid,
  input  logic [W:0]              pe_result,
  output logic [COLADDR_BITS-1:0] WA,
  output logic                    wr_in,
  output logic [W-1:0]            DIN
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Z in a width that can hold it even when Z == 2^COLADDR_BITS, for compares
  localparam logic [COLADDR_BITS:0]   Z_W        = (COLADDR_BITS+1)'(Z);
  // Z modulo 2^COLADDR_BITS; subtracting it wraps correctly in address width
  localparam logic [COLADDR_BITS-1:0] Z_C        = COLADDR_BITS'(Z);
  localparam logic [COLADDR_BITS-1:0] LAST_IDX   = COLADDR_BITS'(Z - 1);
  localparam logic [COLADDR_BITS-1:0] DRAIN_LAST = COLADDR_BITS'(PROC_LAT);

  logic [1:0]              state;
  logic [COLADDR_BITS-1:0] idx;
  logic [COLADDR_BITS-1:0] s;
  logic [COLADDR_BITS-1:0] s_next;
  logic [COLADDR_BITS:0]   ra_sum;
  logic [COLADDR_BITS-1:0] ra_next;
  logic [W-1:0]            din_wb;

  // Read/write delay lines; stage 0 is the RAM read register stage
  logic                    v_pipe [0:PROC_LAT];
  logic [COLADDR_BITS-1:0] a_pipe [0:PROC_LAT];

  // Shift reduction and wrapped read address, using compare-and-subtract only
  always_comb begin
    s_next  = ({1'b0, shift} >= Z_W) ? (shift - Z_C) : shift;
    ra_sum  = {1'b0, idx} + {1'b0, s};
    ra_next = (ra_sum >= Z_W) ? (idx + s - Z_C) : (idx + s);
  end

  assign rd_in    = (state == ST_READ);
  assign busy     = (state == ST_READ) || (state == ST_DRAIN);
  assign done     = (state == ST_DONE);
  assign RA       = rd_in ? ra_next : '0;
  assign pe_data  = ram_dout;
  assign pe_valid = v_pipe[0];
  assign wr_in    = v_pipe[PROC_LAT];
  assign WA       = a_pipe[PROC_LAT];

  // Pass control: idx counts reads in READ and then the drain cycles in DRAIN.
  // The edge that closes DONE may already accept the next start, so
  // back-to-back passes run with no idle gap.
  always_ff @(posedge memclk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      s     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_READ;
            idx   <= '0;
            s     <= s_next;
          end
        end
        ST_READ: begin
          if (idx == LAST_IDX) begin
            state <= ST_DRAIN;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (idx == DRAIN_LAST) begin
            state <= ST_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_READ;
            idx   <= '0;
            s     <= s_next;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Delay the read strobe and address so the write lands 1+PROC_LAT cycles later
  always_ff @(posedge memclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= PROC_LAT; i++) begin
        v_pipe[i] <= 1'b0;
        a_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0] <= rd_in;
      a_pipe[0] <= RA;
      for (int i = 1; i <= PROC_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        a_pipe[i] <= a_pipe[i-1];
      end
    end
  end

`ifdef NE_WB_SAT_EN
  // Clamp the W+1-bit PE result into the signed W-bit range
  always_comb begin
    if (pe_result[W] != pe_result[W-1]) begin
      din_wb = pe_result[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      din_wb = pe_result[W-1:0];
    end
  end
`else
  logic pe_sign_unused;
  assign pe_sign_unused = pe_result[W];

  // Plain truncation of the PE result to W bits
  always_comb begin
    din_wb = pe_result[W-1:0];
  end
`endif

  assign DIN = wr_in ? din_wb : '0;

endmodule

// File: tb/tb_circ_rw_sequencer_ne.sv
// tb_circ_rw_sequencer_ne
// Bench for circ_rw_sequencer_ne with a behavioural column RAM and PE.
// Expected timing and addresses come from the pass arithmetic (offsets from
// the accepting edge, modulo addressing); write-back values come from a
// reference saturate/truncate function and a table of hand-derived vectors.
module tb_circ_rw_sequencer_ne;

  localparam int Z  = 511;
  localparam int W  = 6;
  localparam int CB = 9;
  localparam int L  = 2;
  localparam int NV = 10;

  logic          memclk;
  logic          rst;
  logic          start;
  logic [CB-1:0] shift;
  logic          busy;
  logic          done;
  logic [CB-1:0] RA;
  logic          rd_in;
  logic [W-1:0]  ram_dout;
  logic [W-1:0]  pe_data;
  logic          pe_valid;
  logic [W:0]    pe_result;
  logic [CB-1:0] WA;
  logic          wr_in;
  logic [W-1:0]  DIN;

  circ_rw_sequencer_ne #(
    .Z(Z), .W(W), .COLADDR_BITS(CB), .PROC_LAT(L)
  ) dut (
    .memclk(memclk), .rst(rst), .start(start), .shift(shift),
    .busy(busy), .done(done), .RA(RA), .rd_in(rd_in),
    .ram_dout(ram_dout), .pe_data(pe_data), .pe_valid(pe_valid),
    .pe_result(pe_result), .WA(WA), .wr_in(wr_in), .DIN(DIN)
  );

  typedef struct {
    logic [W:0]   peRes;
    logic [W-1:0] dinTrunc;
    logic [W-1:0] dinSat;
  } dinVec_t;

  dinVec_t      tbl [0:NV-1];
  logic [W-1:0] mem [0:Z-1];
  logic [W-1:0] memBefore [0:Z-1];
  logic [W-1:0] hist [0:Z+L+1];
  int           checks = 0;
  int           errors = 0;

  initial memclk = 1'b0;
  always #5 memclk = ~memclk;

  // Column RAM: registered read, write commits on the edge ending the cycle
  always @(posedge memclk) begin
    if (rd_in) ram_dout <= mem[RA];
    if (wr_in) mem[WA] <= DIN;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] wbRef(input logic [W:0] v);
    int sv;
    logic [W-1:0] r;
    sv = int'($signed(v));
`ifdef NE_WB_SAT_EN
    if (sv > 2**(W-1) - 1) sv = 2**(W-1) - 1;
    else if (sv < -(2**(W-1))) sv = -(2**(W-1));
    r = sv[W-1:0];
`else
    begin
      int m;
      m = ((sv % (2**W)) + 2**W) % (2**W);
      r = m[W-1:0];
    end
`endif
    return r;
  endfunction

  function automatic logic [W:0] peOf(input logic [W-1:0] d, input int delta);
    int v;
    v = int'($signed(d)) + delta;
    return v[W:0];
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"},     int'(busy),     0);
    checkOutput({tag, " done"},     int'(done),     0);
    checkOutput({tag, " rd_in"},    int'(rd_in),    0);
    checkOutput({tag, " pe_valid"}, int'(pe_valid), 0);
    checkOutput({tag, " wr_in"},    int'(wr_in),    0);
    checkOutput({tag, " RA"},       int'(RA),       0);
    checkOutput({tag, " WA"},       int'(WA),       0);
    checkOutput({tag, " DIN"},      int'(DIN),      0);
  endtask

  // Drive start and the PE result for cycle offset k of a pass
  task automatic applyStimulus(input int k, input int mode, input int delta,
                               input bit holdStart);
    int j;
    bit inWr;
    start = holdStart;
    j     = k - 1 - L;
    inWr  = (k >= 1 + L) && (k <= Z + L);
    if (inWr && mode == 1 && j < NV) pe_result = tbl[j].peRes;
    else if (inWr && mode == 0)      pe_result = peOf(hist[k-L], delta);
    else                             pe_result = (W+1)'($urandom);
  endtask

  // One full pass, entered mid-cycle while the DUT is idle
  task automatic runPass(input logic [CB-1:0] sh, input int mode, input int delta,
                         input bit holdStart, input string tag);
    int sr, j, expRa, expWa, bad;
    int misRd, misRa, misPv, misPd, misWr, misWa, misBusy, misDone, misDin;
    bit inRd, inPv, inWr, seen;
    logic [W-1:0] expDin;
    misRd = 0; misRa = 0; misPv = 0; misPd = 0; misWr = 0;
    misWa = 0; misBusy = 0; misDone = 0; misDin = 0;
    sr = int'(sh) % Z;
    memBefore = mem;
    start = 1'b1;
    shift = sh;
    @(posedge memclk);
    for (int k = 0; k <= Z + L + 1; k++) begin
      #1;
      applyStimulus(k, mode, delta, holdStart);
      #1;
      hist[k] = pe_data;
      j     = k - 1 - L;
      inRd  = (k <= Z - 1);
      inPv  = (k >= 1) && (k <= Z);
      inWr  = (k >= 1 + L) && (k <= Z + L);
      expRa = inRd ? (sr + k) % Z : 0;
      expWa = inWr ? (sr + j) % Z : 0;
      if (rd_in !== inRd) misRd++;
      if (int'(RA) != expRa) misRa++;
      if (pe_valid !== inPv) misPv++;
      if (inPv && pe_data !== memBefore[(sr + k - 1) % Z]) misPd++;
      if (wr_in !== inWr) misWr++;
      if (int'(WA) != expWa) misWa++;
      if (busy !== (k <= Z + L)) misBusy++;
      if (done !== (k == Z + L + 1)) misDone++;
      if (inWr && mode == 1 && j < NV) begin
`ifdef NE_WB_SAT_EN
        checkOutput($sformatf("%s DIN vec %0d", tag, j), int'(DIN), int'(tbl[j].dinSat));
`else
        checkOutput($sformatf("%s DIN vec %0d", tag, j), int'(DIN), int'(tbl[j].dinTrunc));
`endif
      end else begin
        expDin = inWr ? wbRef(pe_result) : '0;
        if (DIN !== expDin) misDin++;
      end
      if (k < Z + L + 1) @(posedge memclk);
    end
    checkOutput({tag, " rd_in cycles bad"},    misRd,   0);
    checkOutput({tag, " RA cycles bad"},       misRa,   0);
    checkOutput({tag, " pe_valid cycles bad"}, misPv,   0);
    checkOutput({tag, " pe_data cycles bad"},  misPd,   0);
    checkOutput({tag, " wr_in cycles bad"},    misWr,   0);
    checkOutput({tag, " WA cycles bad"},       misWa,   0);
    checkOutput({tag, " busy cycles bad"},     misBusy, 0);
    checkOutput({tag, " done cycles bad"},     misDone, 0);
    checkOutput({tag, " DIN cycles bad"},      misDin,  0);
    if (mode == 0) begin
      bad = 0;
      for (int a = 0; a < Z; a++)
        if (mem[a] !== wbRef(peOf(memBefore[a], delta))) bad++;
      checkOutput({tag, " RAM words bad"}, bad, 0);
    end
    @(posedge memclk);
    #2;
    if (!holdStart) begin
      checkOutput({tag, " idle after pass"}, int'({busy, rd_in, done}), 0);
    end else begin
      checkOutput({tag, " restart at t0+Z+L+2"},
                  int'(busy && rd_in && int'(RA) == sr), 1);
      start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < Z + L + 10 && !seen; i++) begin
        @(posedge memclk);
        #2;
        if (done) seen = 1'b1;
      end
      checkOutput({tag, " second pass done"}, int'(seen), 1);
      @(posedge memclk);
      #2;
    end
  endtask

  // Start a pass, then pull reset low between edges around idx 200
  task automatic runAbort(input logic [CB-1:0] sh);
    start = 1'b1;
    shift = sh;
    @(posedge memclk);
    #1 start = 1'b0;
    repeat (200) @(posedge memclk);
    #3;
    checkOutput("abort active before reset", int'(rd_in && wr_in && busy && pe_valid), 1);
    rst = 1'b0;
    #1;
    checkAllZero("abort");
    #10 rst = 1'b1;
    @(posedge memclk);
    #2;
    checkOutput("abort idle after release", int'({busy, rd_in, wr_in}), 0);
  endtask

  initial begin
    int d;
    tbl[0] = '{7'b0101000, 6'b101000, 6'b011111};
    tbl[1] = '{7'b1011000, 6'b011000, 6'b100000};
    tbl[2] = '{7'b0000101, 6'b000101, 6'b000101};
    tbl[3] = '{7'b1111011, 6'b111011, 6'b111011};
    tbl[4] = '{7'b0011111, 6'b011111, 6'b011111};
    tbl[5] = '{7'b0100000, 6'b100000, 6'b011111};
    tbl[6] = '{7'b1100000, 6'b100000, 6'b100000};
    tbl[7] = '{7'b1011111, 6'b011111, 6'b100000};
    tbl[8] = '{7'b0111111, 6'b111111, 6'b011111};
    tbl[9] = '{7'b1000000, 6'b000000, 6'b100000};

    rst       = 1'b0;
    start     = 1'b0;
    shift     = '0;
    pe_result = '0;
    for (int a = 0; a < Z; a++) mem[a] = W'(a % 32);
    #12;
    checkAllZero("reset");
    #1 rst = 1'b1;
    @(posedge memclk);
    #2;

    runPass(9'd5,   0, 1, 1'b0, "shift5");
    runPass(9'd0,   0, int'($urandom_range(62, 0)) - 31, 1'b0, "shift0");
    runPass(9'd511, 0, int'($urandom_range(62, 0)) - 31, 1'b0, "shift511");
    runPass(CB'($urandom_range(Z - 1, 0)), 1, 0, 1'b0, "dinTable");
    runPass(9'd7,   0, 1, 1'b1, "holdStart");

    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < Z; a++) mem[a] = W'($urandom);
      d = int'($urandom_range(62, 0)) - 31;
      runPass(CB'($urandom_range(511, 0)), 0, d, 1'b0, $sformatf("random%0d", r));
    end

    runAbort(9'd100);
    runPass(9'd300, 0, 3, 1'b0, "afterAbort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
